// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode map and FSM state encoding shared by the multi-cycle ALU
package ula_pkg;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CALCULA = 2'b01,
        FIM     = 2'b10
    } estado_t;

endpackage

// File: rtl/ula_muldiv_seq.sv
// rtl/ula_muldiv_seq.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
// The go cycle performs the first step, so the final product/quotient sits in p_q when fim is high.
module ula_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               go,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               fim,
    output logic [2*WIDTH-1:0] resultado
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // {hi, lo}: MUL = {partial sum, unconsumed multiplier}; DIV = {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic               div_q, div_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] a);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
        return {s, p[WIDTH-1:1]};
    endfunction

    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH:0] t;
        logic           q;
        t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        q = 1'b0;
        if (t >= {1'b0, b}) begin
            t = t - {1'b0, b};
            q = 1'b1;
        end
        return {t[WIDTH-1:0], p[WIDTH-2:0], q};
    endfunction

    always_comb begin
        p_d    = p_q;
        m_d    = m_q;
        div_d  = div_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (go) begin
            div_d  = is_div;
            m_d    = is_div ? op_b : op_a;
            p_d    = is_div ? div_step({{WIDTH{1'b0}}, op_a}, op_b)
                            : mul_step({{WIDTH{1'b0}}, op_b}, op_a);
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                p_d   = div_q ? div_step(p_q, m_q) : mul_step(p_q, m_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_q    <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            p_q    <= p_d;
            m_q    <= m_d;
            div_q  <= div_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fim       = busy_q && (cnt_q == LAST);
    assign resultado = p_q;

endmodule

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ALU top: control FSM, single-cycle ops, result/flag registers
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   operando1,
    input  logic [WIDTH-1:0]   operando2,
    output logic               ocupado,
    output logic               pronto,
    output logic [2*WIDTH-1:0] resultado,
    output logic               zero,
    output logic               div_zero
);

    estado_t            state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;

    logic [2*WIDTH-1:0] sc_result;
    logic               sc_dz;
    logic               needs_iter;
    logic               md_go;
    logic               md_fim;
    logic [2*WIDTH-1:0] md_result;
    logic [WIDTH:0]     soma_w;
    logic [WIDTH:0]     sub_w;

    assign soma_w = {1'b0, operando1} + {1'b0, operando2};
    // bit WIDTH of the extended difference is the borrow
    assign sub_w  = {1'b0, operando1} - {1'b0, operando2};

    assign needs_iter = (opcode == OP_MUL) ||
                        ((opcode == OP_DIV) && (operando2 != '0));

    always_comb begin
        sc_result = '0;
        sc_dz     = 1'b0;
        case (opcode)
            OP_SOMA: sc_result = {{(WIDTH-1){1'b0}}, soma_w};
            OP_SUB:  sc_result = {{(WIDTH-1){1'b0}}, sub_w};
            OP_DIV: begin
                if (operando2 == '0) begin
                    sc_result = {operando1, {WIDTH{1'b1}}};
                    sc_dz     = 1'b1;
                end
            end
            OP_AND:  sc_result = {{WIDTH{1'b0}}, operando1 & operando2};
            OP_OR:   sc_result = {{WIDTH{1'b0}}, operando1 | operando2};
            OP_NOT:  sc_result = {{WIDTH{1'b0}}, ~operando1};
            OP_XOR:  sc_result = {{WIDTH{1'b0}}, operando1 ^ operando2};
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        dz_d     = dz_q;
        md_go    = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (inicio) begin
                    if (needs_iter) begin
                        md_go   = 1'b1;
                        state_d = CALCULA;
                    end else begin
                        state_d  = FIM;
                        result_d = sc_result;
                        zero_d   = (sc_result == '0);
                        dz_d     = sc_dz;
                    end
                end
            end
            CALCULA: begin
                if (md_fim) begin
                    state_d  = FIM;
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    dz_d     = 1'b0;
                end
            end
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= OCIOSO;
            result_q <= '0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            dz_q     <= dz_d;
        end
    end

    ula_muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clock     (clock),
        .reset     (reset),
        .go        (md_go),
        .is_div    (opcode == OP_DIV),
        .op_a      (operando1),
        .op_b      (operando2),
        .fim       (md_fim),
        .resultado (md_result)
    );

    assign ocupado   = (state_q == CALCULA);
    assign pronto    = (state_q == FIM);
    assign resultado = result_q;
    assign zero      = zero_q;
    assign div_zero  = dz_q;

endmodule
